// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle for the iterative M-extension unit.
// The master side issues operations and consumes results; the unit is the slave.
interface riscv_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a sign fix-up on completion.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | iterating, one bit per cycle
// DONE  | holding the result until consumed
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  riscv_muldiv_unit_if.slave bus
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  logic              accept;
  logic              a_sgn_in;
  logic              b_sgn_in;
  logic              a_neg_in;
  logic              b_neg_in;
  logic [XLEN-1:0]   a_abs_in;
  logic [XLEN-1:0]   b_abs_in;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN:0]     mul_add;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_raw;
  logic [XLEN-1:0]   rem_raw;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;
  logic [XLEN-1:0]   calc_res;

  assign bus.in_ready = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Signed operands: a for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
  assign a_sgn_in = (bus.in_op == 3'b001) || (bus.in_op == 3'b010) ||
                    (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
  assign b_sgn_in = (bus.in_op == 3'b001) || (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
  assign a_neg_in = a_sgn_in && bus.in_a[XLEN-1];
  assign b_neg_in = b_sgn_in && bus.in_b[XLEN-1];
  assign a_abs_in = a_neg_in ? -bus.in_a : bus.in_a;
  assign b_abs_in = b_neg_in ? -bus.in_b : bus.in_b;

  assign div_zero = bus.in_op[2] && (bus.in_b == '0);
  assign div_ovf  = bus.in_op[2] && !bus.in_op[0] && (bus.in_b == '1) &&
                    (bus.in_a == {1'b1, {(XLEN-1){1'b0}}});

  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = bus.in_op[1] ? bus.in_a : '1;
    else
      fast_res = bus.in_op[1] ? '0 : bus.in_a;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_add  = acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}};
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + mul_add;
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    acc_nxt  = {mul_sum, acc[XLEN-1:1]};
    if (op_q[2]) begin
      if (rem_diff[XLEN])
        acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
    prod     = (a_neg ^ b_neg) ? -acc_nxt : acc_nxt;
    quo_raw  = acc_nxt[XLEN-1:0];
    rem_raw  = acc_nxt[2*XLEN-1:XLEN];
    quo      = (a_neg ^ b_neg) ? -quo_raw : quo_raw;
    rmd      = a_neg ? -rem_raw : rem_raw;
    calc_res = '0;
    case (op_q)
      3'b000:                 calc_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quo;
      default:                calc_res = rmd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op_q           <= '0;
      tag_q          <= '0;
      a_neg          <= 1'b0;
      b_neg          <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q  <= bus.in_op;
            tag_q <= bus.in_tag;
            a_neg <= a_neg_in;
            b_neg <= b_neg_in;
            opnd  <= bus.in_op[2] ? b_abs_in : a_abs_in;
            acc   <= {{XLEN{1'b0}}, (bus.in_op[2] ? a_abs_in : b_abs_in)};
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              state          <= DONE;
              bus.out_valid  <= 1'b1;
              bus.out_result <= fast_res;
              bus.out_tag    <= bus.in_tag;
            end else begin
              state         <= CALC;
              bus.out_valid <= 1'b0;
            end
          end else if (state == DONE && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            state          <= DONE;
            bus.out_valid  <= 1'b1;
            bus.out_result <= calc_res;
            bus.out_tag    <= tag_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN = 32): directed cases, handshake
// corner cases, aborts and randomized operations against an arithmetic reference model.
module tb_riscv_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  // Issues one operation, scrambles operands after accept, waits for the result and consumes it.
  // lat is the cycle (relative to the accept cycle k) in which out_valid is first seen, -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] rtag, output int lat);
    int w = 0;
    drive(op, a, b, tag);
    #1;
    while (!bus.in_ready && w < 200) begin
      step();
      w++;
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_op    = 3'($urandom_range(0, 7));
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      step();
      lat++;
    end
    if (!bus.out_valid || w >= 200) lat = -1;
    res  = bus.out_result;
    rtag = bus.out_tag;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 3'b000;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready_held: got %b expected 0", bus.in_ready);
    end
    rst = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_tag !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%h expected 0/0/0",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready_after: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t        v[12];
    logic [31:0] res;
    logic [4:0]  rtag;
    int          lat;
    v[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    v[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 33};
    v[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
    v[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33};
    v[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33};
    v[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 33};
    v[6]  = '{3'b101, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC, 33};
    v[7]  = '{3'b111, 32'd100,        32'd7,         5'd8,  32'd2,         33};
    v[8]  = '{3'b100, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    v[9]  = '{3'b111, 32'd5,          32'd0,         5'd10, 32'd5,         1};
    v[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    v[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0,         1};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].tag, res, rtag, lat);
      n_tests++;
      if (res !== v[i].exp || rtag !== v[i].tag || lat != v[i].lat) begin
        n_fail++;
        $display("FAIL directed_%0d op=%b a=%h b=%h: got result=%h tag=%0d lat=%0d expected result=%h tag=%0d lat=%0d",
                 i, v[i].op, v[i].a, v[i].b, res, rtag, lat, v[i].exp, v[i].tag, v[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    int lat;
    drive(3'b000, 32'd123, 32'd456, 5'd9);
    step();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && w < 100) begin
      step();
      w++;
    end
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd56088 || bus.out_tag !== 5'd9 ||
          bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got valid=%b result=%h tag=%0d in_ready=%b expected 1/%h/9/0",
                 c, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready, 32'd56088);
      end
      step();
    end
    bus.out_ready = 1'b1;
    drive(3'b101, 32'd9, 32'd3, 5'd17);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_same_cycle_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_valid_drop: got %b expected 0", bus.out_valid);
    end
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    n_tests++;
    if (lat != 33 || bus.out_result !== 32'd3 || bus.out_tag !== 5'd17) begin
      n_fail++;
      $display("FAIL backpressure_next_result: got lat=%0d result=%h tag=%0d expected 33/3/17",
               lat, bus.out_result, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w = 0;
    int n_valid = 0;
    int first = -1;
    int second = -1;
    drive(3'b111, 32'd100, 32'd7, 5'd3);
    step();
    bus.in_valid = 1'b0;
    while (!bus.out_valid && w < 100) begin
      step();
      w++;
    end
    bus.out_ready = 1'b1;
    drive(3'b100, 32'd5, 32'd0, 5'd4);
    step();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF || bus.out_tag !== 5'd4) begin
      n_fail++;
      $display("FAIL b2b_fast_path: got valid=%b result=%h tag=%0d expected 1/ffffffff/4",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    step();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_valid_drop: got %b expected 0", bus.out_valid);
    end
    // Streaming with out_ready tied high: one result every XLEN+1 cycles.
    drive(3'b101, 32'd1000, 32'd10, 5'd21);
    step();
    for (int c = 1; c <= 70; c++) begin
      if (bus.out_valid) begin
        n_valid++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      step();
    end
    bus.in_valid = 1'b0;
    repeat (40) step();
    bus.out_ready = 1'b0;
    n_tests++;
    if (n_valid != 2 || first != 33 || second != 66) begin
      n_fail++;
      $display("FAIL b2b_throughput: got pulses=%0d at %0d,%0d expected 2 at 33,66",
               n_valid, first, second);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    drive(3'b000, $urandom, $urandom, 5'd7);
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mid_op: got in_ready=%b valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    repeat (40) begin
      step();
      if (bus.out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen);
    end
    seen = 0;
    drive(3'b100, 32'd5, 32'd0, 5'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    repeat (40) begin
      if (bus.out_valid) seen++;
      step();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_blocks_accept: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_rst_abort();
    logic [31:0] res;
    logic [4:0]  rtag;
    int          lat;
    int          seen = 0;
    run_op(3'b000, 32'd3, 32'd5, 5'd6, res, rtag, lat);
    n_tests++;
    if (res !== 32'd15 || rtag !== 5'd6 || lat != 33) begin
      n_fail++;
      $display("FAIL rst_pre_op: got result=%h tag=%0d lat=%0d expected f/6/33", res, rtag, lat);
    end
    drive(3'b000, 32'd11, 32'd13, 5'd14);
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_tag !== 5'h0 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_abort_outputs: got valid=%b result=%h tag=%0d in_ready=%b expected 0/0/0/1",
               bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready);
    end
    repeat (40) begin
      step();
      if (bus.out_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_result: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic [4:0]  rtag;
    logic [31:0] exp;
    int          lat;
    int          exp_lat;
    for (int i = 0; i < 150; i++) begin
      op  = 3'($urandom_range(0, 7));
      tag = 5'($urandom_range(0, 31));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      exp     = ref_model(op, a, b);
      exp_lat = ref_latency(op, a, b);
      run_op(op, a, b, tag, res, rtag, lat);
      n_tests++;
      if (res !== exp || rtag !== tag || lat != exp_lat) begin
        n_fail++;
        $display("FAIL random_%0d op=%b a=%h b=%h: got result=%h tag=%0d lat=%0d expected result=%h tag=%0d lat=%0d",
                 i, op, a, b, res, rtag, lat, exp, tag, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rst_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
# riscv_muldiv_unit

Iterative, parametrised RV32M/RV64M multiply/divide unit sitting beside the single-cycle ALU and extending the `alu_op_t` set with the eight M-extension operations. It accepts one operation at a time over a valid/ready handshake, computes over XLEN cycles with shift-add multiply and restoring divide, and returns the result with a pass-through destination tag. Division-by-zero and signed-overflow cases take a one-cycle fast path.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- TAG_W, 5: width of the opaque tag (rd index) carried with each operation.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  abort any in-flight operation, synchronous.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 operand (multiplicand / dividend).
- in_b  in  XLEN  rs2 operand (multiplier / divisor).
- in_tag  in  TAG_W  tag returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the operation that produced out_result.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: holding the result.
- Accept: the unit accepts a request when `in_valid && in_ready && !flush` at a rising edge. On accept it latches op and tag, records the operand signs, and stores the absolute values of the operands:
  - a is treated as signed for MULH, MULHSU, DIV and REM.
  - b is treated as signed for MULH, DIV and REM.
  - All other operand cases are unsigned.
- Fast path on accept, going straight to DONE:
  - Divisor == 0:
    - DIV/DIVU result = all ones.
    - REM/REMU result = in_a.
  - Signed overflow (DIV/REM with a = 100...0, b = all ones):
    - DIV result = in_a.
    - REM result = 0.
- Normal path: the unit enters CALC with iteration counter = 0. It performs one iteration per cycle and moves to DONE after the iteration with counter = XLEN-1.
  - Multiply: 2*XLEN-bit accumulator, radix-2 shift-add of |a| by |b|.
  - Divide: restoring, XLEN-bit quotient/remainder on |a| / |b|.
- Sign fix-up, applied on the transition into DONE:
  - Product is negated (2*XLEN-bit two's complement) when the operand signs differ.
  - Quotient is negated when the signs of a and b differ.
  - Remainder takes the sign of a.
- Result selection:
  - MUL returns the low XLEN bits of the product.
  - MULH/MULHSU/MULHU return the high XLEN bits.
  - DIV/DIVU return the quotient.
  - REM/REMU return the remainder.
- in_ready = (state == IDLE) || (state == DONE && out_ready). A result can be consumed and a new request accepted in the same cycle.
- DONE → IDLE when `out_ready && !(in_valid accepted)`. DONE → CALC/DONE when a new request is accepted in the same cycle.
- flush: from any state the unit goes to IDLE on the next edge and drops any result. flush has priority over accept; no request is accepted in a flush cycle.
- rst: same effect as flush, plus it clears all outputs. It has priority over everything else.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_tag 0, counter 0. in_ready is forced 0 while rst is high and is 1 in the first cycle after rst deasserts.
- With a request accepted at the end of cycle k:
  - Normal path: out_valid = 1 in cycle k+XLEN+1 (cycle k+33 for XLEN = 32).
  - Fast path: out_valid = 1 in cycle k+1.
- While out_valid is high and out_ready is low, out_result, out_tag and out_valid hold stable and in_ready = 0.
- out_valid drops in the cycle after the handshake, unless a back-to-back fast-path operation was accepted in the handshake cycle; in that case out_valid stays high with the new result.
- Throughput: one normal-path operation per XLEN+1 cycles with out_ready tied high.
- Inputs are not sampled after accept; changing in_a/in_b during CALC has no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), tag 5, accepted in cycle k → out_result 0xFFFFFFEB, out_tag 5, out_valid first high in cycle k+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD.
  - REM -7 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 100 / 7 → 2.
- Special cases:
  - DIV 5 / 0 → 0xFFFFFFFF at k+1.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at k+1.
  - REM of the same operands → 0.
- Backpressure:
  - Hold out_ready low for 10 cycles after out_valid → result stable and in_ready 0 throughout.
  - Then assert out_ready together with in_valid (DIVU 9/3) → accepted in the same cycle, next result 3 arrives 33 cycles later.
- Abort:
  - Assert flush at counter = 10 during MUL → state IDLE the next cycle, in_ready 1, no out_valid ever for that operation.
  - Assert flush together with in_valid → request not accepted.
  - Repeat the mid-operation abort with rst → all outputs 0.
